// File: rtl/cache_assoc_pkg.sv
// Shared state encoding and default sizing for the two-way set-associative cache controller.
package cache_assoc_pkg;

    localparam int unsigned DEF_WORDS_PER_LINE = 4;
    localparam int unsigned DEF_MEM_LAT        = 2;
    localparam int unsigned DEF_INDEX_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WB       = 3'd1,
        ST_FILL     = 3'd2,
        ST_FINAL_WR = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } state_t;

    // Replacement choice on a miss: first invalid way (way 0 first), else the LRU way.
    function automatic logic pick_victim(input logic valid0, input logic valid1, input logic lru);
        logic v;
        if (!valid0) begin
            v = 1'b0;
        end else if (!valid1) begin
            v = 1'b1;
        end else begin
            v = lru;
        end
        return v;
    endfunction

endpackage

// File: rtl/cache_lru_array.sv
// One LRU bit per set: combinational read, clocked write, cleared by reset.
module cache_lru_array
    import cache_assoc_pkg::*;
#(
    parameter int unsigned INDEX_W = DEF_INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_lru,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_lru
);

    localparam int unsigned SETS = 1 << INDEX_W;

    logic [SETS-1:0] lru_q;

    // Read port: the bit of the set being looked up this cycle.
    assign rd_lru = lru_q[rd_index];

    // Write port: record which way becomes least recently used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru_q <= '0;
        end else if (wr_en) begin
            lru_q[wr_index] <= wr_lru;
        end
    end

endmodule

// File: rtl/cache_assoc_controller.sv
// Two-way set-associative cache controller: hit handling, dirty write-back,
// pipelined line fill and LRU maintenance.
module cache_assoc_controller
    import cache_assoc_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int unsigned MEM_LAT        = DEF_MEM_LAT,
    parameter int unsigned INDEX_W        = DEF_INDEX_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rd,
    input  logic                              wr,
    input  logic [INDEX_W-1:0]                index,
    input  logic                              hit0,
    input  logic                              hit1,
    input  logic                              valid0,
    input  logic                              valid1,
    input  logic                              dirty0,
    input  logic                              dirty1,
    input  logic                              cache_err,
    input  logic                              mem_err,
    input  logic                              mem_stall,
    output logic                              comp,
    output logic                              cache_write,
    output logic                              way_sel,
    output logic [$clog2(WORDS_PER_LINE)-1:0] word_off,
    output logic                              mem_rd,
    output logic                              mem_wr,
    output logic                              stall,
    output logic                              done,
    output logic                              cache_hit,
    output logic                              err
);

    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned CNT_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] LINE_WORDS = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS_PER_LINE - 1);

    state_t               state_q, state_d;
    logic [INDEX_W-1:0]   idx_q, idx_d;
    logic                 wr_q, wr_d;
    logic                 way_q, way_d;
    logic                 hit_q, hit_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     ret_q, ret_d;
    logic [MEM_LAT-1:0]   pend_q, pend_d;

    logic                 hit0_v, hit1_v, any_hit, hit_way;
    logic                 lru_rd, lru_we;
    logic                 victim, victim_wb;
    logic                 ret_now, issue_ok, issue_acc;

    // Tag-compare qualification and miss replacement choice.
    assign hit0_v    = hit0 & valid0;
    assign hit1_v    = hit1 & valid1;
    assign any_hit   = hit0_v | hit1_v;
    assign hit_way   = ~hit0_v & hit1_v;
    assign victim    = pick_victim(valid0, valid1, lru_rd);
    assign victim_wb = valid0 & valid1 & (victim ? dirty1 : dirty0);

    cache_lru_array #(
        .INDEX_W (INDEX_W)
    ) u_lru (
        .clk      (clk),
        .rst      (rst),
        .rd_index (index),
        .rd_lru   (lru_rd),
        .wr_en    (lru_we),
        .wr_index (idx_q),
        .wr_lru   (~way_q)
    );

    // State, latched request and burst counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            way_q   <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            ret_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            way_q   <= way_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_d        = wr_q;
        way_d       = way_q;
        hit_d       = hit_q;
        cnt_d       = cnt_q;
        ret_d       = ret_q;
        pend_d      = pend_q;
        comp        = 1'b0;
        cache_write = 1'b0;
        way_sel     = 1'b0;
        word_off    = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        stall       = (state_q != ST_IDLE);
        done        = 1'b0;
        cache_hit   = 1'b0;
        err         = 1'b0;
        lru_we      = 1'b0;
        ret_now     = 1'b0;
        issue_ok    = 1'b0;
        issue_acc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                comp   = 1'b1;
                cnt_d  = '0;
                ret_d  = '0;
                pend_d = '0;
                // Request-driven outputs are held quiet while reset is asserted.
                if (!rst) begin
                    cache_write = wr;
                    way_sel     = hit_way;
                end
                if (rd || wr) begin
                    idx_d = index;
                    wr_d  = wr;
                    if (any_hit) begin
                        way_d   = hit_way;
                        hit_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        way_d   = victim;
                        hit_d   = 1'b0;
                        state_d = victim_wb ? ST_WB : ST_FILL;
                    end
                end
            end

            ST_WB: begin
                mem_wr   = 1'b1;
                way_sel  = way_q;
                word_off = cnt_q[OFF_W-1:0];
                if (!mem_stall) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = ST_FILL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_FILL: begin
                // A returning word owns the array port; the read issue waits that cycle.
                ret_now   = pend_q[MEM_LAT-1];
                issue_ok  = (cnt_q < LINE_WORDS) && !ret_now;
                issue_acc = issue_ok && !mem_stall;
                pend_d    = MEM_LAT'({pend_q, issue_acc});
                if (issue_acc) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (ret_now) begin
                    cache_write = 1'b1;
                    way_sel     = way_q;
                    word_off    = ret_q[OFF_W-1:0];
                    ret_d       = ret_q + CNT_W'(1);
                    if (ret_q == LAST_WORD) begin
                        state_d = wr_q ? ST_FINAL_WR : ST_DONE;
                    end
                end else if (issue_ok) begin
                    mem_rd   = 1'b1;
                    word_off = cnt_q[OFF_W-1:0];
                end
            end

            ST_FINAL_WR: begin
                comp        = 1'b1;
                cache_write = 1'b1;
                way_sel     = way_q;
                state_d     = ST_DONE;
            end

            ST_DONE: begin
                done      = 1'b1;
                cache_hit = hit_q;
                lru_we    = 1'b1;
                state_d   = ST_IDLE;
            end

            ST_ERR: begin
                err     = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && (cache_err || mem_err)) begin
            state_d = ST_ERR;
        end
    end

endmodule

// File: tb/tb_cache_assoc_controller.sv
// Scoreboard bench for cache_assoc_controller: a transaction-level reference model
// predicts timed output events; a negedge monitor pops and compares them.
module tb_cache_assoc_controller;

    localparam int W     = 4;
    localparam int LAT   = 2;
    localparam int IW    = 8;
    localparam int PAT_N = 256;

    logic          clk, rst;
    logic          rd, wr;
    logic [IW-1:0] index;
    logic          hit0, hit1, valid0, valid1, dirty0, dirty1;
    logic          cache_err, mem_err, mem_stall;
    logic          comp, cache_write, way_sel, mem_rd, mem_wr, stall, done, cache_hit, err;
    logic [1:0]    word_off;

    cache_assoc_controller #(
        .WORDS_PER_LINE (W),
        .MEM_LAT        (LAT),
        .INDEX_W        (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd          (rd),
        .wr          (wr),
        .index       (index),
        .hit0        (hit0),
        .hit1        (hit1),
        .valid0      (valid0),
        .valid1      (valid1),
        .dirty0      (dirty0),
        .dirty1      (dirty1),
        .cache_err   (cache_err),
        .mem_err     (mem_err),
        .mem_stall   (mem_stall),
        .comp        (comp),
        .cache_write (cache_write),
        .way_sel     (way_sel),
        .word_off    (word_off),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .stall       (stall),
        .done        (done),
        .cache_hit   (cache_hit),
        .err         (err)
    );

    typedef enum int {EV_HITWR, EV_WB, EV_ISSUE, EV_FILL, EV_FINAL, EV_DONE} ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       off;
        int       way;
        int       hit;
        int       er;
        int       t;
    } ev_t;

    ev_t exp_q[$];
    ev_t txn_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    bit  lru_m [256];
    bit  stall_pat [PAT_N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    function automatic bit pat(input int r);
        return (r >= 0 && r < PAT_N) ? stall_pat[r] : 1'b0;
    endfunction

    function automatic void push_ev(input ev_kind_t k, input int off, input int way,
                                    input int hit, input int er, input int t);
        ev_t e;
        e.kind = k; e.off = off; e.way = way; e.hit = hit; e.er = er; e.t = t;
        txn_q.push_back(e);
    endfunction

    // Reference model: the timed event list one request produces.
    function automatic void model(input bit wr_op, input int idx,
                                  input bit h0, input bit v0, input bit h1, input bit v1,
                                  input bit d0, input bit d1, input int t0,
                                  output int t_done, output bit used);
        int t, issued, returned;
        int rq[$];
        bit hway, vic;
        txn_q.delete();
        hway = !(h0 && v0) && (h1 && v1);
        if (wr_op) push_ev(EV_HITWR, 0, int'(hway), 0, 0, t0);
        if ((h0 && v0) || (h1 && v1)) begin
            push_ev(EV_DONE, 0, 0, 1, 0, t0 + 1);
            t_done = t0 + 1;
            used   = hway;
        end else begin
            vic = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_m[idx]);
            t = t0 + 1;
            if (v0 && v1 && (vic ? d1 : d0)) begin
                for (int k = 0; k < W; k++) begin
                    while (pat(t - t0)) t++;
                    push_ev(EV_WB, k, int'(vic), 0, 0, t);
                    t++;
                end
            end
            issued = 0;
            returned = 0;
            while (returned < W) begin
                if (rq.size() > 0 && rq[0] == t) begin
                    push_ev(EV_FILL, returned, int'(vic), 0, 0, t);
                    returned++;
                    void'(rq.pop_front());
                end else if (issued < W && !pat(t - t0)) begin
                    push_ev(EV_ISSUE, issued, 0, 0, 0, t);
                    rq.push_back(t + LAT);
                    issued++;
                end
                t++;
            end
            if (wr_op) begin
                push_ev(EV_FINAL, 0, int'(vic), 0, 0, t);
                t++;
            end
            push_ev(EV_DONE, 0, 0, 0, 0, t);
            t_done = t;
            used   = vic;
        end
    endfunction

    task automatic observe(input ev_kind_t k, input int off, input int way, input int hit, input int er);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d got %s off=%0d way=%0d hit=%0d err=%0d, required no event",
                     cyc, k.name(), off, way, hit, er);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.off != off || e.way != way || e.hit != hit || e.er != er || e.t != cyc) begin
                failures++;
                $display("FAIL event got %s off=%0d way=%0d hit=%0d err=%0d cyc=%0d, required %s off=%0d way=%0d hit=%0d err=%0d cyc=%0d",
                         k.name(), off, way, hit, er, cyc, e.kind.name(), e.off, e.way, e.hit, e.er, e.t);
            end
        end
    endtask

    // Monitor: turn observable DUT activity into events and score them.
    always @(negedge clk) begin
        if (!rst) begin
            if (done)                           observe(EV_DONE, 0, 0, int'(cache_hit), int'(err));
            if (mem_wr && !mem_stall)           observe(EV_WB, int'(word_off), int'(way_sel), 0, 0);
            if (mem_rd && !mem_stall)           observe(EV_ISSUE, int'(word_off), 0, 0, 0);
            if (cache_write && !comp)           observe(EV_FILL, int'(word_off), int'(way_sel), 0, 0);
            if (cache_write && comp && stall)   observe(EV_FINAL, 0, int'(way_sel), 0, 0);
            if (cache_write && comp && !stall)  observe(EV_HITWR, 0, int'(way_sel), 0, 0);
        end
    end

    task automatic check_reset(input string name);
        logic [10:0] got;
        got = {comp, cache_write, way_sel, mem_rd, mem_wr, stall, done, cache_hit, err, word_off};
        checks++;
        if (got !== 11'h400) begin
            failures++;
            $display("FAIL %s outputs got %b, required %b", name, got, 11'h400);
        end
    endtask

    task automatic clr_pat();
        for (int i = 0; i < PAT_N; i++) stall_pat[i] = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Issue one request, enqueue its predicted events, then run until it completes.
    task automatic run_txn(input bit wr_op, input int idx,
                           input bit h0, input bit v0, input bit h1, input bit v1,
                           input bit d0, input bit d1,
                           input int err_rel, input bit err_sel, input int rst_rel);
        int  t0, t_done, end_t, limit, r;
        bit  used;
        @(posedge clk); #1;
        t0 = cyc;
        rd = wr_op ? 1'($urandom) : 1'b1;
        wr = wr_op;
        index = IW'(idx);
        hit0 = h0; valid0 = v0; hit1 = h1; valid1 = v1; dirty0 = d0; dirty1 = d1;
        mem_stall = pat(0);
        cache_err = 1'b0;
        mem_err = 1'b0;
        model(wr_op, idx, h0, v0, h1, v1, d0, d1, t0, t_done, used);
        if (err_rel > 0) begin
            limit = t0 + err_rel;
            end_t = limit + 1;
        end else if (rst_rel > 0) begin
            limit = t0 + rst_rel - 1;
            end_t = t0 + rst_rel;
        end else begin
            limit = t_done;
            end_t = t_done;
            lru_m[idx] = ~used;
        end
        foreach (txn_q[i]) if (txn_q[i].t <= limit) exp_q.push_back(txn_q[i]);
        if (err_rel > 0) begin
            ev_t e;
            e.kind = EV_DONE; e.off = 0; e.way = 0; e.hit = 0; e.er = 1; e.t = end_t;
            exp_q.push_back(e);
        end
        while (cyc < end_t) begin
            @(posedge clk); #1;
            r = cyc - t0;
            rd = 1'($urandom); wr = 1'($urandom); index = IW'($urandom);
            hit0 = 1'($urandom); hit1 = 1'($urandom); valid0 = 1'($urandom);
            valid1 = 1'($urandom); dirty0 = 1'($urandom); dirty1 = 1'($urandom);
            mem_stall = pat(r);
            mem_err   = (err_rel > 0 && r == err_rel && !err_sel);
            cache_err = (err_rel > 0 && r == err_rel && err_sel);
            if (rst_rel > 0 && r == rst_rel) begin
                rst = 1'b1;
                #1;
                check_reset("reset_mid_fill");
                @(posedge clk); #1;
                rst = 1'b0;
                rd = 1'b0;
                wr = 1'b0;
                for (int i = 0; i < 256; i++) lru_m[i] = 1'b0;
            end
        end
        rd = 1'b0; wr = 1'b0; mem_err = 1'b0; cache_err = 1'b0; mem_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rd = 1'b0; wr = 1'b1; index = '0;
        hit0 = 1'b0; hit1 = 1'b1; valid0 = 1'b0; valid1 = 1'b1; dirty0 = 1'b0; dirty1 = 1'b0;
        cache_err = 1'b0; mem_err = 1'b0; mem_stall = 1'b0;
        for (int i = 0; i < 256; i++) lru_m[i] = 1'b0;
        clr_pat();
        #3;
        check_reset("reset_initial");
        @(posedge clk); #1;
        check_reset("reset_held");
        @(posedge clk); #1;
        rst = 1'b0;
        wr = 1'b0; hit1 = 1'b0; valid1 = 1'b0;

        // Read hit on way 1 of set 5.
        run_txn(1'b0, 5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        // Way-0 hit on set 3 makes way 1 the LRU way there.
        run_txn(1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        // Write miss, both valid, LRU way 1 dirty: write-back, fill, final write.
        run_txn(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
        // Read miss with way 0 invalid: fill only.
        run_txn(1'b0, 9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0);
        // Miss on set 5 after the way-1 hit: way 0 is the victim.
        run_txn(1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        // Memory stall held three cycles on write-back word 2.
        clr_pat();
        stall_pat[3] = 1'b1; stall_pat[4] = 1'b1; stall_pat[5] = 1'b1;
        run_txn(1'b0, 7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0);
        clr_pat();
        // Memory error during fill; LRU of set 5 must stay on way 1.
        run_txn(1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 0);
        run_txn(1'b0, 5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
        // Cache error during write-back.
        run_txn(1'b1, 12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 0);
        // Reset in the second fill cycle, then confirm the LRU bits were cleared.
        run_txn(1'b0, 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 2);
        run_txn(1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0);

        // Randomized traffic on a few sets so the LRU state is exercised.
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < PAT_N; i++) stall_pat[i] = ($urandom_range(0, 3) == 0);
            run_txn(1'($urandom), $urandom_range(0, 7),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 0, 1'b0, 0);
            idle_gap($urandom_range(0, 2));
        end

        idle_gap(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending events, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
